// File: rtl/de2_115_ledg_pwm.sv
// Green-LED PWM stage behind the LEDG PIO: per-LED brightness, optional linear fade,
// configured through a zero-wait-state Avalon-MM slave.
module de2_115_ledg_pwm #(
    parameter int NUM_LEDS = 9,
    parameter int PWM_BITS = 8
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [NUM_LEDS-1:0] led_in,
    input  logic [1:0]          address,
    input  logic                chipselect,
    input  logic                write_n,
    input  logic [31:0]         writedata,
    output logic [31:0]         readdata,
    output logic [NUM_LEDS-1:0] led_out
);

    logic [PWM_BITS-1:0] bright;
    logic [15:0]         prescale;
    logic                en;
    logic                fade;

    logic [NUM_LEDS-1:0] led_q;
    logic [PWM_BITS-1:0] level  [NUM_LEDS];
    logic [PWM_BITS-1:0] target [NUM_LEDS];
    logic [NUM_LEDS-1:0] settled;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic [15:0]         presc_cnt;

    logic wr;
    logic tick;
    logic unused_wdata;

    assign wr           = chipselect && !write_n;
    assign tick         = en && (presc_cnt == 16'd0);
    assign unused_wdata = ^writedata[31:16];

    always_comb begin
        for (int i = 0; i < NUM_LEDS; i++) begin
            target[i]  = led_q[i] ? bright : '0;
            settled[i] = (level[i] == target[i]);
        end
    end

    always_comb begin
        readdata = '0;
        case (address)
            2'd0: readdata[PWM_BITS-1:0] = bright;
            2'd1: readdata[15:0]         = prescale;
            2'd2: readdata[1:0]          = {fade, en};
            2'd3: readdata[NUM_LEDS-1:0] = settled;
            default: readdata = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bright   <= '1;
            prescale <= '0;
            en       <= 1'b1;
            fade     <= 1'b0;
        end else if (wr) begin
            case (address)
                2'd0: bright   <= writedata[PWM_BITS-1:0];
                2'd1: prescale <= writedata[15:0];
                2'd2: begin
                    en   <= writedata[0];
                    fade <= writedata[1];
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            led_q <= '0;
        end else begin
            led_q <= led_in;
        end
    end

    // A PRESCALE write restarts the interval at once; the tick of that cycle still used the old count.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pwm_cnt   <= '0;
            presc_cnt <= '0;
        end else if (!en) begin
            pwm_cnt   <= '0;
            presc_cnt <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + 1'b1;
            if (wr && address == 2'd1) begin
                presc_cnt <= writedata[15:0];
            end else if (presc_cnt == 16'd0) begin
                presc_cnt <= prescale;
            end else begin
                presc_cnt <= presc_cnt - 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_LEDS; i++) begin
                level[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_LEDS; i++) begin
                if (!en) begin
                    level[i] <= '0;
                end else if (!fade) begin
                    level[i] <= target[i];
                end else if (tick && (level[i] < target[i])) begin
                    level[i] <= level[i] + 1'b1;
                end else if (tick && (level[i] > target[i])) begin
                    level[i] <= level[i] - 1'b1;
                end
            end
        end
    end

    // Strict compare: level L is lit for exactly L of the 2**PWM_BITS counter phases.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            led_out <= '0;
        end else begin
            for (int i = 0; i < NUM_LEDS; i++) begin
                led_out[i] <= en && (level[i] > pwm_cnt);
            end
        end
    end

endmodule

// File: tb/tb_de2_115_ledg_pwm.sv
// Self-checking bench for de2_115_ledg_pwm: duty counts, fade timing and reset behaviour
// compared against expectations computed from brightness/prescale arithmetic.
module tb_de2_115_ledg_pwm;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [8:0]  led_in = '0;
    logic [1:0]  address = '0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = '0;
    logic [31:0] readdata;
    logic [8:0]  led_out;

    int n_checks = 0;
    int n_fail   = 0;
    int duty [9];

    de2_115_ledg_pwm #(.NUM_LEDS(9), .PWM_BITS(8)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .led_in     (led_in),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .led_out    (led_out)
    );

    always #5 clk = ~clk;

    // Reference: a level reached after n ticks spaced prescale+1 cycles apart.
    function automatic int ramp_cycles(input int ticks, input int p);
        return ticks * (p + 1);
    endfunction

    function automatic int exp_duty(input logic [8:0] mask, input int i, input int b);
        return mask[i] ? b : 0;
    endfunction

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic reg_write(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(posedge clk);
        #1;
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic reg_read(input logic [1:0] a, output logic [31:0] d);
        address = a;
        #1;
        d = readdata;
    endtask

    task automatic measure_duty();
        for (int i = 0; i < 9; i++) duty[i] = 0;
        for (int c = 0; c < 256; c++) begin
            step(1);
            for (int i = 0; i < 9; i++) if (led_out[i]) duty[i]++;
        end
    endtask

    task automatic check_duty(input string name, input logic [8:0] mask, input int b);
        measure_duty();
        for (int i = 0; i < 9; i++) begin
            n_checks++;
            if (duty[i] !== exp_duty(mask, i, b)) begin
                n_fail++;
                $display("FAIL %s led%0d: high %0d cycles, expected %0d", name, i, duty[i], exp_duty(mask, i, b));
            end
        end
    endtask

    // Counts edges until STATUS[bit] reads 1, bounded by limit.
    task automatic wait_settled(input int bit_idx, input int limit, output int cycles);
        logic [31:0] rd;
        cycles = 0;
        reg_read(2'd3, rd);
        while (!rd[bit_idx] && cycles < limit) begin
            step(1);
            cycles++;
            reg_read(2'd3, rd);
        end
        if (!rd[bit_idx]) cycles = -1;
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic check_hex(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    // Levels to 0 with FADE off, then arm FADE with brightness b.
    task automatic fade_setup(input int b);
        reg_write(2'd2, 32'h1);
        led_in = '0;
        step(4);
        reg_write(2'd0, b);
        reg_write(2'd2, 32'h3);
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        step(3);
        check_hex("reset led_out during reset", {23'd0, led_out}, 32'h0);
        reset_n = 1'b1;
        step(2);
        check_hex("reset led_out", {23'd0, led_out}, 32'h0);
        reg_read(2'd0, rd); check_hex("reset BRIGHT", rd, 32'hFF);
        reg_read(2'd1, rd); check_hex("reset PRESCALE", rd, 32'h0);
        reg_read(2'd2, rd); check_hex("reset CTRL", rd, 32'h1);
        reg_read(2'd3, rd); check_hex("reset STATUS", rd, 32'h1FF);
    endtask

    task automatic test_static_duty();
        int          b;
        logic [8:0]  mask;
        logic [31:0] rd;
        reg_write(2'd2, 32'h1);
        for (int it = 0; it < 5; it++) begin
            if (it == 0) begin
                b = 32'h40;
                mask = 9'h1FF;
            end else begin
                b = $urandom_range(1, 254);
                mask = 9'($urandom);
            end
            reg_write(2'd0, b);
            led_in = mask;
            step(6);
            reg_read(2'd3, rd);
            check_hex("static STATUS", rd, 32'h1FF);
            check_duty("static duty", mask, b);
        end
    endtask

    task automatic test_boundary();
        logic [31:0] rd;
        reg_write(2'd0, 32'hFF);
        led_in = 9'h001;
        step(6);
        check_duty("duty bright 0xFF", 9'h001, 255);
        reg_write(2'd0, 32'h00);
        led_in = 9'h1FF;
        step(6);
        reg_read(2'd3, rd);
        check_hex("bright 0 STATUS", rd, 32'h1FF);
        check_duty("duty bright 0x00", 9'h1FF, 0);
    endtask

    task automatic test_fade_up();
        int          b, p, idx, cyc;
        logic [31:0] rd;
        for (int it = 0; it < 4; it++) begin
            if (it == 0) begin
                b = 16; p = 3; idx = 1;
            end else begin
                b = $urandom_range(2, 40); p = $urandom_range(0, 3); idx = $urandom_range(0, 8);
            end
            fade_setup(b);
            led_in = 9'(1 << idx);
            reg_write(2'd1, p);
            reg_read(2'd3, rd);
            check_int("fade STATUS low at ramp start", int'(rd[idx]), 0);
            wait_settled(idx, 2000, cyc);
            check_int("fade up cycles", cyc, ramp_cycles(b, p));
            reg_read(2'd3, rd);
            check_hex("fade end STATUS", rd, 32'h1FF);
        end
        check_duty("duty after fade", 9'(1 << idx), b);
    endtask

    task automatic test_ramp_reversal();
        int b, p, cyc;
        for (int it = 0; it < 2; it++) begin
            b = (it == 0) ? 16 : $urandom_range(9, 40);
            p = (it == 0) ? 3 : $urandom_range(0, 3);
            fade_setup(b);
            led_in = 9'h002;
            reg_write(2'd1, p);
            step(ramp_cycles(8, p) - 1);
            led_in = 9'h000;
            wait_settled(1, 2000, cyc);
            check_int("reversal cycles", cyc, ramp_cycles(8, p) + 1);
        end
    endtask

    task automatic test_bright_retarget();
        int p, cyc;
        p = 1;
        fade_setup(20);
        led_in = 9'h001;
        reg_write(2'd1, p);
        step(ramp_cycles(10, p) - 1);
        reg_write(2'd0, 4);
        wait_settled(0, 2000, cyc);
        check_int("retarget down cycles", cyc, ramp_cycles(6, p));
        check_duty("duty after retarget", 9'h001, 4);
    endtask

    task automatic test_fade_clear();
        logic [31:0] rd;
        fade_setup(40);
        led_in = 9'h004;
        reg_write(2'd1, 3);
        step(10);
        reg_write(2'd2, 32'h1);
        reg_read(2'd3, rd);
        check_int("fade clear STATUS before snap", int'(rd[2]), 0);
        step(1);
        reg_read(2'd3, rd);
        check_int("fade clear STATUS after snap", int'(rd[2]), 1);
        check_duty("duty after snap", 9'h004, 40);
    endtask

    task automatic test_disable();
        int          b, p, cyc;
        logic [31:0] rd;
        b = 30; p = 3;
        fade_setup(b);
        led_in = 9'h1FF;
        reg_write(2'd1, p);
        step(40);
        reg_write(2'd2, 32'h2);
        step(1);
        check_hex("disable led_out", {23'd0, led_out}, 32'h0);
        reg_read(2'd3, rd);
        check_hex("disable STATUS", rd, 32'h0);
        check_duty("duty disabled", 9'h1FF, 0);
        // Prescaler idles at 0, so the first tick lands on the first enabled cycle.
        reg_write(2'd2, 32'h3);
        wait_settled(5, 2000, cyc);
        check_int("re-enable fade cycles", cyc, 1 + ramp_cycles(b - 1, p));
    endtask

    task automatic test_async_reset();
        logic [31:0] rd;
        reg_write(2'd2, 32'h1);
        reg_write(2'd0, 32'hFF);
        reg_write(2'd1, 32'h1234);
        led_in = 9'h1FF;
        step(10);
        #2;
        reset_n = 1'b0;
        #1;
        check_hex("async reset led_out", {23'd0, led_out}, 32'h0);
        reg_read(2'd1, rd); check_hex("async reset PRESCALE", rd, 32'h0);
        reg_read(2'd2, rd); check_hex("async reset CTRL", rd, 32'h1);
        reg_read(2'd3, rd); check_hex("async reset STATUS", rd, 32'h1FF);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        reg_read(2'd0, rd); check_hex("post reset BRIGHT", rd, 32'hFF);
    endtask

    initial begin
        test_reset();
        test_static_duty();
        test_boundary();
        test_fade_up();
        test_ramp_reversal();
        test_bright_retarget();
        test_fade_clear();
        test_disable();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
